// File: rtl/wall_follower_fsm.sv
// wall_follower_fsm: registered left/right-hand wall follower with stuck detection and a step counter
module wall_follower_fsm #(
  parameter int STEP_W = 8,
  parameter int MAX_ROT = 4,
  localparam int ROT_W = $clog2(MAX_ROT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              head,
  input  logic              wall,
  input  logic              follow_right,
  output logic              front,
  output logic              rot_l,
  output logic              rot_r,
  output logic              stuck,
  output logic [1:0]        state,
  output logic [STEP_W-1:0] steps
);
  typedef enum logic [1:0] {SEARCH, FOLLOW, TURN, STUCK} state_t;
  state_t st, nxt;
  logic mode, m, aw, tw, fw, rot, hit;
  logic [ROT_W-1:0] rot_cnt, rot_nxt;
  assign state = st;
  // in SEARCH the freshly sampled follow_right already steers this cycle's rotation
  always_comb begin
    m = (st == SEARCH) ? follow_right : mode;
    aw = head && st != STUCK;
    tw = !head && st == FOLLOW && !wall;
    fw = !head && st != STUCK && !tw;
    rot = aw || tw;
    rot_nxt = rot_cnt + ROT_W'(1);
    hit = rot && rot_nxt == ROT_W'(MAX_ROT);
    nxt = st == STUCK ? STUCK : head ? TURN : tw ? SEARCH : wall ? FOLLOW : SEARCH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= SEARCH;
      {front, rot_l, rot_r, stuck, mode} <= '0;
      rot_cnt <= '0;
      steps <= '0;
    end else if (clr) begin
      st <= SEARCH;
      {front, rot_l, rot_r, stuck} <= '0;
      rot_cnt <= '0;
      steps <= '0;
    end else if (!en) begin
      {front, rot_l, rot_r} <= '0;
    end else begin
      front <= fw;
      rot_l <= (aw && m) || (tw && !m);
      rot_r <= (aw && !m) || (tw && m);
      mode <= (st == SEARCH) ? follow_right : mode;
      rot_cnt <= rot ? rot_nxt : fw ? '0 : rot_cnt;
      steps <= (fw && steps != '1) ? steps + STEP_W'(1) : steps;
      st <= hit ? STUCK : nxt;
      stuck <= hit || st == STUCK;
    end
  end
endmodule

// File: tb/tb_wall_follower_fsm.sv
// tb_wall_follower_fsm: scoreboard bench; a reference model queues expected outputs per driven edge
module tb_wall_follower_fsm;
  logic clk = 0, rst_n = 0, en = 0, clr = 0, head = 0, wall = 0, follow_right = 0;
  logic front, rot_l, rot_r, stuck, s_front, s_rot_l, s_rot_r, s_stuck;
  logic [1:0] state, s_state;
  logic [7:0] steps;
  logic [2:0] s_steps;
  typedef struct {
    logic front, rot_l, rot_r, stuck;
    logic [1:0] state;
    logic [7:0] steps;
  } exp_t;
  exp_t q[$];
  int nvec = 0, nmis = 0;
  int ms = 0, mrot = 0, msteps = 0;
  bit mmode = 0;
  always #5 clk = ~clk;
  wall_follower_fsm dut (.clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .head(head), .wall(wall),
    .follow_right(follow_right), .front(front), .rot_l(rot_l), .rot_r(rot_r), .stuck(stuck),
    .state(state), .steps(steps));
  wall_follower_fsm #(.STEP_W(3)) dut_s (.clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .head(head),
    .wall(wall), .follow_right(follow_right), .front(s_front), .rot_l(s_rot_l), .rot_r(s_rot_r),
    .stuck(s_stuck), .state(s_state), .steps(s_steps));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model(bit e, bit c, bit h, bit w, bit f);
    exp_t x;
    bit md, away, tow, fwd;
    int ns;
    x = '{default: '0};
    away = 0; tow = 0; fwd = 0; ns = ms;
    if (c) begin
      ms = 0; mrot = 0; msteps = 0;
    end else if (e) begin
      md = (ms == 0) ? f : mmode;
      if (ms == 0) mmode = f;
      case (ms)
        0: begin away = h; fwd = !h; ns = h ? 2 : w ? 1 : 0; end
        1: begin away = h; fwd = !h && w; tow = !h && !w; ns = h ? 2 : w ? 1 : 0; end
        2: begin away = h; fwd = !h; ns = h ? 2 : w ? 1 : 0; end
        default: ns = 3;
      endcase
      if (away || tow) begin
        mrot++;
        x.rot_r = away ? !md : md;
        x.rot_l = !x.rot_r;
        if (mrot == 4) ns = 3;
      end
      if (fwd) begin
        mrot = 0;
        x.front = 1;
        if (msteps < 255) msteps++;
      end
      ms = ns;
    end
    x.state = ms[1:0];
    x.stuck = (ms == 3);
    x.steps = msteps[7:0];
    q.push_back(x);
  endtask
  task automatic drive(bit e, bit c, bit h, bit w, bit f, string tag);
    exp_t x;
    en = e; clr = c; head = h; wall = w; follow_right = f;
    model(e, c, h, w, f);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk({tag, ".front"}, front, x.front);
    chk({tag, ".rot_l"}, rot_l, x.rot_l);
    chk({tag, ".rot_r"}, rot_r, x.rot_r);
    chk({tag, ".stuck"}, stuck, x.stuck);
    chk({tag, ".state"}, state, x.state);
    chk({tag, ".steps"}, steps, x.steps);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out", {front, rot_l, rot_r, stuck, state, steps}, 0);
    @(negedge clk);
    rst_n = 1;
    drive(1, 0, 0, 0, 0, "t1a");
    chk("t1a.c", {front, state}, 3'b100);
    drive(1, 0, 0, 0, 0, "t1b");
    drive(1, 0, 0, 1, 0, "t1c");
    chk("t1c.c", {front, state}, 3'b101);
    drive(1, 0, 1, 0, 0, "t1d");
    chk("t1d.c", {rot_r, state}, 3'b110);
    drive(1, 0, 0, 1, 0, "t1e");
    chk("t1.steps", steps, 4);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 0, "t2rot");
    chk("t2.stuck", {rot_r, stuck, state}, 4'b1111);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0, "t2hold");
    chk("t2.hold", {front, rot_l, rot_r, state}, 5'b00011);
    drive(1, 1, 0, 1, 0, "t2clr");
    chk("t2.clr", {stuck, state, steps}, 0);
    drive(1, 0, 1, 0, 1, "t3a");
    chk("t3a.rot_l", rot_l, 1);
    drive(1, 0, 0, 1, 0, "t3b");
    drive(1, 0, 0, 0, 0, "t3c");
    chk("t3c.c", {rot_r, state}, 3'b100);
    drive(1, 1, 0, 0, 0, "t4clr");
    chk("t4.sclr", s_steps, 0);
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 0, 0, 0, "t4");
      chk("t4.ssteps", s_steps, i < 7 ? i : 7);
      chk("t4.sfront", s_front, 1);
    end
    drive(1, 0, 1, 0, 0, "t5turn");
    for (int i = 0; i < 3; i++) drive(0, 0, i[0] ? 0 : 1, 0, 0, "t5en0");
    chk("t5.hold", {front, rot_l, rot_r, state}, 5'b00010);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0, 0, "t5rot");
    chk("t5.stuck", state, 3);
    drive(1, 1, 1, 0, 0, "t5clr");
    for (int i = 0; i < 60; i++)
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom),
        1'($urandom), "rnd");
    drive(1, 1, 0, 0, 0, "t6clr");
    drive(1, 0, 0, 0, 0, "t6a");
    #2 rst_n = 0;
    #1;
    chk("t6.async", {front, steps, state}, 0);
    ms = 0; mrot = 0; msteps = 0; mmode = 0;
    @(negedge clk);
    rst_n = 1;
    drive(1, 0, 0, 1, 0, "t6b");
    chk("t6.after", {front, state}, 3'b101);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
